lc3b_branch_history: RTL

Parametrised global branch-history unit for the LC-3b pipeline: the successor to the single 4-bit history shifter. It keeps a speculative history, shifted at prediction time in fetch, and an architectural history, shifted at resolution in execute. An in-order FIFO holds up to DEPTH unresolved predictions. On a mispredict the speculative history is repaired from the architectural history and all younger in-flight predictions are discarded.

---
 rtl/lc3b_branch_history.sv | 72 +++++++
 1 files changed

// File: rtl/lc3b_branch_history.sv
// lc3b_branch_history: speculative and architectural global branch history with mispredict repair.
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   pred_valid, pred_taken      prediction from fetch; accepted when pred_ready
//   pred_ready                  prediction FIFO not full (combinational from count)
//   resolve_valid, resolve_taken oldest in-flight branch resolved in execute
//   spec_hist, commit_hist      speculative and resolved-only histories
//   mispredict                  one-cycle pulse after a wrong prediction is resolved
//   inflight                    number of unresolved predictions held
module lc3b_branch_history #(
    parameter int HIST_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic [HIST_W-1:0]          spec_hist,
    output logic [HIST_W-1:0]          commit_hist,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] q;
    logic [PW-1:0]    head, tail, head_nx, tail_nx;
    logic [CW-1:0]    count;
    logic             accept, resolve, miss;
    always_comb begin
        pred_ready = count < CW'(DEPTH);
        accept     = pred_valid && pred_ready;
        resolve    = resolve_valid && count != '0;
        miss       = resolve && resolve_taken != q[head];
        head_nx    = head == PW'(DEPTH-1) ? '0 : head + PW'(1);
        tail_nx    = tail == PW'(DEPTH-1) ? '0 : tail + PW'(1);
        inflight   = count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            spec_hist   <= '0;
            commit_hist <= '0;
            mispredict  <= 1'b0;
            q           <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            mispredict <= miss;
            if (resolve)
                commit_hist <= {commit_hist[HIST_W-2:0], resolve_taken};
            if (miss) begin
                // Repair wins over a same-cycle accept: that prediction is wrong-path.
                spec_hist <= {commit_hist[HIST_W-2:0], resolve_taken};
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end else begin
                if (accept) begin
                    spec_hist <= {spec_hist[HIST_W-2:0], pred_taken};
                    q[tail]   <= pred_taken;
                    tail      <= tail_nx;
                end
                if (resolve)
                    head <= head_nx;
                count <= count + CW'(accept) - CW'(resolve);
            end
        end
    end
endmodule
